uart_transmitter: RTL and testbench

UART transmitter, the transmit-side counterpart of the team's UART receiver. Serialises one data word per valid/ready transfer onto i_uart_tx-compatible line o_uart_tx, one bit per i_u_clk cycle (i_u_clk is the bit-rate clock). Frame format is start (0), data LSB first, optional parity, then stop (1) bits, so it is directly loop-backable into the receiver built with the same parameters.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_transmitter.sv | 135 +++++++++++++
 tb/tb_uart_transmitter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : parity modes, transmitter FSM encoding, frame length       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int UART_CHECK_NONE = 0;
  localparam int UART_CHECK_ODD  = 1;
  localparam int UART_CHECK_EVEN = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int unsigned uart_frame_len(input int unsigned w,
                                                 input int unsigned check,
                                                 input int unsigned s);
    return 1 + w + ((check > 0) ? 1 : 0) + s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_transmitter : valid/ready word in, start/data/parity/stop out    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int P_UART_DATA_WIDTH = 8,
  parameter int P_UART_STOP_WIDTH = 1,
  parameter int P_UART_CHECK      = 0
) (
  input  logic                         i_u_clk,
  input  logic                         i_u_rst_n,
  input  logic [P_UART_DATA_WIDTH-1:0] i_uart_tx_data,
  input  logic                         i_uart_tx_valid,
  output logic                         o_uart_tx_ready,
  output logic                         o_uart_tx,
  output logic                         o_uart_tx_busy
);

  generate
    if ((P_UART_CHECK != UART_CHECK_NONE) && (P_UART_CHECK != UART_CHECK_ODD) &&
        (P_UART_CHECK != UART_CHECK_EVEN)) begin : g_bad_check
      $error("uart_transmitter: P_UART_CHECK must be 0, 1 or 2");
    end
    if ((P_UART_DATA_WIDTH < 5) || (P_UART_DATA_WIDTH > 8) ||
        (P_UART_STOP_WIDTH < 1) || (P_UART_STOP_WIDTH > 2)) begin : g_bad_width
      $error("uart_transmitter: data width 5..8, stop width 1..2");
    end
  endgenerate

  localparam logic [3:0] c_DATA_LAST = 4'(P_UART_DATA_WIDTH - 1);
  localparam logic [3:0] c_STOP_LAST = 4'(P_UART_STOP_WIDTH - 1);

  logic [2:0]                   r_state;
  logic [3:0]                   r_cnt;
  logic [P_UART_DATA_WIDTH-1:0] r_shift;
  logic                         r_parity;
  logic                         r_tx;
  logic                         r_busy;

  logic w_last_stop;
  logic w_ready;
  logic w_accept;
  logic w_parity_bit;

  assign w_last_stop  = (r_state == ST_STOP) && (r_cnt == c_STOP_LAST);
  assign w_ready      = i_u_rst_n && ((r_state == ST_IDLE) || w_last_stop);
  assign w_accept     = i_uart_tx_valid && w_ready;
  assign w_parity_bit = (P_UART_CHECK == UART_CHECK_ODD) ? ~r_parity : r_parity;

  // Each edge loads r_tx with the bit of the state being entered, so the line
  // trails the accept by exactly one cycle.
  always_ff @(posedge i_u_clk) begin
    if (!i_u_rst_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 4'd0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_busy   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_state  <= ST_START;
            r_cnt    <= 4'd0;
            r_shift  <= i_uart_tx_data;
            r_parity <= 1'b0;
            r_tx     <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        ST_START: begin
          r_state  <= ST_DATA;
          r_cnt    <= 4'd0;
          r_tx     <= r_shift[0];
          r_shift  <= r_shift >> 1;
          r_parity <= r_parity ^ r_shift[0];
        end
        ST_DATA: begin
          if (r_cnt == c_DATA_LAST) begin
            r_cnt <= 4'd0;
            if (P_UART_CHECK != UART_CHECK_NONE) begin
              r_state <= ST_PARITY;
              r_tx    <= w_parity_bit;
            end else begin
              r_state <= ST_STOP;
              r_tx    <= 1'b1;
            end
          end else begin
            r_cnt    <= r_cnt + 4'd1;
            r_tx     <= r_shift[0];
            r_shift  <= r_shift >> 1;
            r_parity <= r_parity ^ r_shift[0];
          end
        end
        ST_PARITY: begin
          r_state <= ST_STOP;
          r_cnt   <= 4'd0;
          r_tx    <= 1'b1;
        end
        ST_STOP: begin
          if (r_cnt == c_STOP_LAST) begin
            r_cnt <= 4'd0;
            if (w_accept) begin
              r_state  <= ST_START;
              r_shift  <= i_uart_tx_data;
              r_parity <= 1'b0;
              r_tx     <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_uart_tx_ready = w_ready;
  assign o_uart_tx       = r_tx;
  assign o_uart_tx_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_transmitter : directed frames on default, odd and even DUTs   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_uart_transmitter;

  logic       clk;
  logic       rst_n;
  logic [7:0] r_data0, r_data1, r_data2;
  logic       r_valid0, r_valid1, r_valid2;
  logic       w_ready0, w_ready1, w_ready2;
  logic       w_tx0, w_tx1, w_tx2;
  logic       w_busy0, w_busy1, w_busy2;

  int n_checks = 0;
  int n_fail   = 0;

  // dut0: 8N1, dut1: 8O1, dut2: 8E2
  uart_transmitter #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)) u_dut0 (
    .i_u_clk(clk), .i_u_rst_n(rst_n), .i_uart_tx_data(r_data0), .i_uart_tx_valid(r_valid0),
    .o_uart_tx_ready(w_ready0), .o_uart_tx(w_tx0), .o_uart_tx_busy(w_busy0));
  uart_transmitter #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(1), .P_UART_CHECK(1)) u_dut1 (
    .i_u_clk(clk), .i_u_rst_n(rst_n), .i_uart_tx_data(r_data1), .i_uart_tx_valid(r_valid1),
    .o_uart_tx_ready(w_ready1), .o_uart_tx(w_tx1), .o_uart_tx_busy(w_busy1));
  uart_transmitter #(.P_UART_DATA_WIDTH(8), .P_UART_STOP_WIDTH(2), .P_UART_CHECK(2)) u_dut2 (
    .i_u_clk(clk), .i_u_rst_n(rst_n), .i_uart_tx_data(r_data2), .i_uart_tx_valid(r_valid2),
    .o_uart_tx_ready(w_ready2), .o_uart_tx(w_tx2), .o_uart_tx_busy(w_busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input int d, input logic [7:0] data, input logic valid);
    case (d)
      0: begin r_data0 = data; r_valid0 = valid; end
      1: begin r_data1 = data; r_valid1 = valid; end
      default: begin r_data2 = data; r_valid2 = valid; end
    endcase
  endtask

  function automatic logic [2:0] outs(input int d);  // {ready, busy, tx}
    case (d)
      0:       return {w_ready0, w_busy0, w_tx0};
      1:       return {w_ready1, w_busy1, w_tx1};
      default: return {w_ready2, w_busy2, w_tx2};
    endcase
  endfunction

  // exp bit i is the line value in cycle i after the accepting edge
  task automatic run_frame(input int d, input logic [7:0] data, input logic [11:0] exp,
                           input int len, input string name);
    logic [2:0] o;
    o = outs(d);
    check_eq($sformatf("%s ready_idle", name), 32'(o[2]), 32'd1);
    set_in(d, data, 1'b1);
    tick();
    set_in(d, 8'h00, 1'b0);
    for (int i = 0; i < len; i++) begin
      o = outs(d);
      check_eq($sformatf("%s tx[%0d]", name, i), 32'(o[0]), 32'(exp[i]));
      check_eq($sformatf("%s busy[%0d]", name, i), 32'(o[1]), 32'd1);
      check_eq($sformatf("%s ready[%0d]", name, i), 32'(o[2]), 32'(i == len - 1));
      tick();
    end
    o = outs(d);
    check_eq($sformatf("%s tx_after", name), 32'(o[0]), 32'd1);
    check_eq($sformatf("%s busy_after", name), 32'(o[1]), 32'd0);
  endtask

  logic [19:0] exp20;

  initial begin
    rst_n = 1'b0;
    set_in(0, 8'h00, 1'b0);
    set_in(1, 8'h00, 1'b0);
    set_in(2, 8'h00, 1'b0);

    // reset held 3 cycles, then idle
    for (int i = 0; i < 3; i++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        check_eq($sformatf("rst d%0d out", d), 32'(outs(d)), 32'b001);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      for (int d = 0; d < 3; d++) begin
        check_eq($sformatf("idle d%0d out", d), 32'(outs(d)), 32'b101);
      end
    end

    run_frame(0, 8'hA5, 12'h34A, 10, "a5_8n1");
    run_frame(1, 8'h07, 12'h40E, 11, "07_odd");
    run_frame(2, 8'h07, 12'hE0E, 12, "07_even_s2");

    // back-to-back: 0x00 then 0xFF with valid held high
    exp20 = {10'h3FE, 10'h200};
    set_in(0, 8'h00, 1'b1);
    tick();
    for (int i = 0; i < 20; i++) begin
      if (i == 0)  set_in(0, 8'hFF, 1'b1);
      if (i == 10) set_in(0, 8'h00, 1'b0);
      check_eq($sformatf("b2b tx[%0d]", i), 32'(w_tx0), 32'(exp20[i]));
      check_eq($sformatf("b2b busy[%0d]", i), 32'(w_busy0), 32'd1);
      check_eq($sformatf("b2b ready[%0d]", i), 32'(w_ready0), 32'((i == 9) || (i == 19)));
      tick();
    end
    check_eq("b2b busy_end", 32'(w_busy0), 32'd0);

    // hold-off: 0x3C offered during a 0x81 frame
    exp20 = {10'h278, 10'h302};
    set_in(0, 8'h81, 1'b1);
    tick();
    set_in(0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i == 2)  set_in(0, 8'h3C, 1'b1);
      if (i == 10) set_in(0, 8'hC3, 1'b0);
      check_eq($sformatf("hold tx[%0d]", i), 32'(w_tx0), 32'(exp20[i]));
      check_eq($sformatf("hold busy[%0d]", i), 32'(w_busy0), 32'd1);
      check_eq($sformatf("hold ready[%0d]", i), 32'(w_ready0), 32'((i == 9) || (i == 19)));
      tick();
    end
    check_eq("hold busy_end", 32'(w_busy0), 32'd0);

    // reset during data bit 4 of 0x5A, then a clean 0x5A
    set_in(0, 8'h5A, 1'b1);
    tick();
    set_in(0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    check_eq("midrst pre_tx_bit4", 32'(w_tx0), 32'd1);
    rst_n = 1'b0;
    check_eq("midrst ready_low", 32'(w_ready0), 32'd0);
    tick();
    check_eq("midrst out", 32'(outs(0)), 32'b001);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq($sformatf("midrst idle[%0d]", i), 32'(outs(0)), 32'b101);
    end
    run_frame(0, 8'h5A, 12'h2B4, 10, "5a_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
